// File: rtl/rtc_calendar_core.sv
// rtc_calendar_core
// Real-time clock / calendar core: seconds prescaler, sec/min/hour/day/month/year
// registers with a single-edge carry chain, leap-year aware day count, field-wise
// set (increment / decrement with wrap, no carry), 12/24 h display and HH:MM alarm.
//
// Ports
//   clock         in   system clock
//   reset         in   asynchronous, active-low
//   i_run         in   1 = timekeeping enabled, 0 = prescaler frozen
//   i_set_field   in   0 none, 1 sec, 2 min, 3 hour, 4 day, 5 month, 6 year, 7 none
//   i_set_inc     in   1-cycle pulse, increment selected field
//   i_set_dec     in   1-cycle pulse, decrement selected field
//   i_mode_12h    in   selects o_hour_disp format
//   i_alarm_en    in   alarm enable
//   i_alarm_hour  in   alarm hour 0..23
//   i_alarm_min   in   alarm minute 0..59
//   o_sec/o_min   out  0..59
//   o_hour        out  0..23 (always 24 h)
//   o_hour_disp   out  1..12 in 12 h mode, else o_hour
//   o_pm          out  hour >= 12
//   o_day         out  1..days_in_month
//   o_month       out  1..12
//   o_year        out  0..YEAR_MAX (offset from 2000)
//   o_sec_tick    out  1-cycle pulse when seconds advance
//   o_alarm_hit   out  1-cycle pulse on alarm match
module rtc_calendar_core #(
   parameter int TICK_DIV = 32768,
   parameter int PRE_W    = 16,
   parameter int YEAR_MAX = 99,
   parameter int YEAR_W   = 7
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_run,
   input  logic [2:0]        i_set_field,
   input  logic              i_set_inc,
   input  logic              i_set_dec,
   input  logic              i_mode_12h,
   input  logic              i_alarm_en,
   input  logic [4:0]        i_alarm_hour,
   input  logic [5:0]        i_alarm_min,
   output logic [5:0]        o_sec,
   output logic [5:0]        o_min,
   output logic [4:0]        o_hour,
   output logic [4:0]        o_hour_disp,
   output logic              o_pm,
   output logic [4:0]        o_day,
   output logic [3:0]        o_month,
   output logic [YEAR_W-1:0] o_year,
   output logic              o_sec_tick,
   output logic              o_alarm_hit
);

   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [YEAR_W-1:0] YR_LAST  = YEAR_W'(YEAR_MAX);

   localparam logic [2:0] F_SEC   = 3'd1;
   localparam logic [2:0] F_MIN   = 3'd2;
   localparam logic [2:0] F_HOUR  = 3'd3;
   localparam logic [2:0] F_DAY   = 3'd4;
   localparam logic [2:0] F_MONTH = 3'd5;
   localparam logic [2:0] F_YEAR  = 3'd6;

   // Years are offsets from 2000, so year%4==0 is a leap year across the whole range.
   function automatic logic [4:0] f_dim(input logic [3:0] month, input logic [YEAR_W-1:0] year);
      logic [4:0] dim;
      case (month)
         4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
         4'd2:                    dim = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
         default:                 dim = 5'd31;
      endcase
      return dim;
   endfunction

   logic [PRE_W-1:0]  r_pre;
   logic [5:0]        r_sec;
   logic [5:0]        r_min;
   logic [4:0]        r_hour;
   logic [4:0]        r_day;
   logic [3:0]        r_month;
   logic [YEAR_W-1:0] r_year;
   logic              r_sec_tick;
   logic              r_alarm_hit;

   logic              w_set_mode;
   logic              w_inc;
   logic              w_dec;
   logic              w_tick;
   logic              w_alarm;
   logic [4:0]        w_dim_cur;
   logic [4:0]        w_dim_new;
   logic [5:0]        w_sec_n;
   logic [5:0]        w_min_n;
   logic [4:0]        w_hour_n;
   logic [4:0]        w_day_n;
   logic [3:0]        w_month_n;
   logic [YEAR_W-1:0] w_year_n;
   logic [4:0]        w_hour_disp;

   assign w_set_mode = (i_set_field != 3'd0) && (i_set_field != 3'd7);
   assign w_inc      = i_set_inc & ~i_set_dec;
   assign w_dec      = i_set_dec & ~i_set_inc;
   assign w_tick     = ~w_set_mode & i_run & (r_pre == PRE_LAST);
   assign w_dim_cur  = f_dim(r_month, r_year);

   always_comb begin
      w_sec_n   = r_sec;
      w_min_n   = r_min;
      w_hour_n  = r_hour;
      w_day_n   = r_day;
      w_month_n = r_month;
      w_year_n  = r_year;

      if (w_tick) begin
         if (r_sec == 6'd59) begin
            w_sec_n = 6'd0;
            if (r_min == 6'd59) begin
               w_min_n = 6'd0;
               if (r_hour == 5'd23) begin
                  w_hour_n = 5'd0;
                  if (r_day >= w_dim_cur) begin
                     w_day_n = 5'd1;
                     if (r_month == 4'd12) begin
                        w_month_n = 4'd1;
                        w_year_n  = (r_year == YR_LAST) ? '0 : r_year + YEAR_W'(1);
                     end else begin
                        w_month_n = r_month + 4'd1;
                     end
                  end else begin
                     w_day_n = r_day + 5'd1;
                  end
               end else begin
                  w_hour_n = r_hour + 5'd1;
               end
            end else begin
               w_min_n = r_min + 6'd1;
            end
         end else begin
            w_sec_n = r_sec + 6'd1;
         end
      end else if (w_set_mode && (w_inc || w_dec)) begin
         case (i_set_field)
            F_SEC: w_sec_n = w_inc ? ((r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1)
                                   : ((r_sec == 6'd0) ? 6'd59 : r_sec - 6'd1);
            F_MIN: w_min_n = w_inc ? ((r_min == 6'd59) ? 6'd0 : r_min + 6'd1)
                                   : ((r_min == 6'd0) ? 6'd59 : r_min - 6'd1);
            F_HOUR: w_hour_n = w_inc ? ((r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1)
                                     : ((r_hour == 5'd0) ? 5'd23 : r_hour - 5'd1);
            F_DAY: w_day_n = w_inc ? ((r_day >= w_dim_cur) ? 5'd1 : r_day + 5'd1)
                                   : ((r_day <= 5'd1) ? w_dim_cur : r_day - 5'd1);
            F_MONTH: w_month_n = w_inc ? ((r_month == 4'd12) ? 4'd1 : r_month + 4'd1)
                                       : ((r_month == 4'd1) ? 4'd12 : r_month - 4'd1);
            F_YEAR: w_year_n = w_inc ? ((r_year == YR_LAST) ? '0 : r_year + YEAR_W'(1))
                                     : ((r_year == '0) ? YR_LAST : r_year - YEAR_W'(1));
            default: ;
         endcase
      end

      // Day clamp: harmless when month/year are unchanged (day already fits),
      // and a month carry has already forced day to 1.
      w_dim_new = f_dim(w_month_n, w_year_n);
      if (w_day_n > w_dim_new) begin
         w_day_n = w_dim_new;
      end
   end

   assign w_alarm = w_tick && (r_sec == 6'd59) && i_alarm_en &&
                    (w_hour_n == i_alarm_hour) && (w_min_n == i_alarm_min);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pre       <= '0;
         r_sec       <= 6'd0;
         r_min       <= 6'd0;
         r_hour      <= 5'd0;
         r_day       <= 5'd1;
         r_month     <= 4'd1;
         r_year      <= '0;
         r_sec_tick  <= 1'b0;
         r_alarm_hit <= 1'b0;
      end else begin
         // Holding the prescaler at 0 in set mode makes the first tick after
         // leaving set mode a full second away.
         if (w_set_mode) begin
            r_pre <= '0;
         end else if (i_run) begin
            r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + PRE_W'(1);
         end
         r_sec       <= w_sec_n;
         r_min       <= w_min_n;
         r_hour      <= w_hour_n;
         r_day       <= w_day_n;
         r_month     <= w_month_n;
         r_year      <= w_year_n;
         r_sec_tick  <= w_tick;
         r_alarm_hit <= w_alarm;
      end
   end

   always_comb begin
      w_hour_disp = r_hour;
      if (i_mode_12h) begin
         if (r_hour == 5'd0) begin
            w_hour_disp = 5'd12;
         end else if (r_hour > 5'd12) begin
            w_hour_disp = r_hour - 5'd12;
         end
      end
   end

   assign o_sec       = r_sec;
   assign o_min       = r_min;
   assign o_hour      = r_hour;
   assign o_hour_disp = w_hour_disp;
   assign o_pm        = (r_hour >= 5'd12);
   assign o_day       = r_day;
   assign o_month     = r_month;
   assign o_year      = r_year;
   assign o_sec_tick  = r_sec_tick;
   assign o_alarm_hit = r_alarm_hit;

endmodule

// File: tb/tb_rtc_calendar_core.sv
module tb_rtc_calendar_core;

   localparam int YW = 7;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          i_run = 1'b1;
   logic [2:0]    i_set_field = 3'd1;
   logic          i_set_inc = 1'b0;
   logic          i_set_dec = 1'b0;
   logic          i_mode_12h = 1'b0;
   logic          i_alarm_en = 1'b0;
   logic [4:0]    i_alarm_hour = 5'd0;
   logic [5:0]    i_alarm_min = 6'd0;
   logic [5:0]    o_sec, o_min;
   logic [4:0]    o_hour, o_hour_disp, o_day;
   logic          o_pm, o_sec_tick, o_alarm_hit;
   logic [3:0]    o_month;
   logic [YW-1:0] o_year;

   rtc_calendar_core #(.TICK_DIV(4), .PRE_W(2), .YEAR_MAX(99), .YEAR_W(YW)) dut (
      .clock(clock), .reset(reset), .i_run(i_run), .i_set_field(i_set_field),
      .i_set_inc(i_set_inc), .i_set_dec(i_set_dec), .i_mode_12h(i_mode_12h),
      .i_alarm_en(i_alarm_en), .i_alarm_hour(i_alarm_hour), .i_alarm_min(i_alarm_min),
      .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_hour_disp(o_hour_disp),
      .o_pm(o_pm), .o_day(o_day), .o_month(o_month), .o_year(o_year),
      .o_sec_tick(o_sec_tick), .o_alarm_hit(o_alarm_hit)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [5:0]    sec;
      logic [5:0]    min;
      logic [4:0]    hour;
      logic [4:0]    day;
      logic [3:0]    month;
      logic [YW-1:0] year;
      logic [4:0]    hdisp;
      logic          pm;
      logic          alarm;
      int            cyc;
   } exp_t;

   exp_t  q_tick[$];
   string q_tick_nm[$];
   exp_t  q_snap[$];
   string q_snap_nm[$];
   bit    snap_req = 1'b0;
   int    cyc = 0;
   int    tests = 0;
   int    fails = 0;

   always @(posedge clock) cyc <= cyc + 1;

   function automatic exp_t mk(int h, int m, int s, int d, int mo, int y, int hd, int pm, int al);
      exp_t e;
      e.sec = 6'(s); e.min = 6'(m); e.hour = 5'(h); e.day = 5'(d); e.month = 4'(mo);
      e.year = YW'(y); e.hdisp = 5'(hd); e.pm = 1'(pm); e.alarm = 1'(al); e.cyc = -1;
      return e;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("%0d:%0d:%0d %0d/%0d/%0d disp=%0d pm=%0d alarm=%0d",
                       e.hour, e.min, e.sec, e.day, e.month, e.year, e.hdisp, e.pm, e.alarm);
   endfunction

   function automatic logic [39:0] pack(exp_t e);
      return {e.sec, e.min, e.hour, e.day, e.month, e.year, e.hdisp, e.pm, e.alarm};
   endfunction

   function automatic exp_t actual();
      exp_t a;
      a.sec = o_sec; a.min = o_min; a.hour = o_hour; a.day = o_day; a.month = o_month;
      a.year = o_year; a.hdisp = o_hour_disp; a.pm = o_pm; a.alarm = o_alarm_hit; a.cyc = cyc;
      return a;
   endfunction

   // Monitor: pops an expected entry whenever the DUT ticks or a snapshot is requested.
   always @(negedge clock) begin
      exp_t a, e;
      string nm;
      a = actual();
      if (o_sec_tick) begin
         tests++;
         if (q_tick.size() == 0) begin
            fails++;
            $display("FAIL unexpected_tick: got tick at cycle %0d, required none (%s)", cyc, fmt(a));
         end else begin
            e = q_tick.pop_front();
            nm = q_tick_nm.pop_front();
            if (pack(a) != pack(e)) begin
               fails++;
               $display("FAIL %s: actual %s, required %s", nm, fmt(a), fmt(e));
            end
            if (e.cyc >= 0) begin
               tests++;
               if (cyc != e.cyc) begin
                  fails++;
                  $display("FAIL %s_timing: tick at cycle %0d, required %0d", nm, cyc, e.cyc);
               end
            end
         end
      end else if (o_alarm_hit) begin
         tests++;
         fails++;
         $display("FAIL alarm_without_tick: alarm_hit=1 at cycle %0d, required 0", cyc);
      end
      if (snap_req && q_snap.size() > 0) begin
         e = q_snap.pop_front();
         nm = q_snap_nm.pop_front();
         tests++;
         if (pack(a) != pack(e)) begin
            fails++;
            $display("FAIL %s: actual %s, required %s", nm, fmt(a), fmt(e));
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic snap(input string nm, input exp_t e);
      q_snap.push_back(e);
      q_snap_nm.push_back(nm);
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
   endtask

   task automatic pulse(input int f, input bit inc, input int n);
      i_set_field = 3'(f);
      for (int i = 0; i < n; i++) begin
         if (inc) i_set_inc = 1'b1; else i_set_dec = 1'b1;
         step();
         i_set_inc = 1'b0;
         i_set_dec = 1'b0;
         step();
      end
   endtask

   // Move one field from its minimum to target by the shorter direction.
   task automatic adj(input int f, input int target, input int range, input int minval);
      int k;
      k = target - minval;
      if (k != 0) begin
         if (k <= range / 2) pulse(f, 1'b1, k);
         else pulse(f, 1'b0, range - k);
      end
   endtask

   task automatic do_reset();
      i_set_field = 3'd1;
      i_set_inc = 1'b0;
      i_set_dec = 1'b0;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic set_time(input int h, input int m, input int s, input int d, input int mo,
                           input int y, input int dim);
      do_reset();
      adj(6, y, 100, 0);
      adj(5, mo, 12, 1);
      adj(4, d, dim, 1);
      adj(3, h, 24, 0);
      adj(2, m, 60, 0);
      adj(1, s, 60, 0);
   endtask

   // Leave set mode; the tick is due exactly 4 cycles later.
   task automatic release_tick(input string nm, input exp_t e);
      exp_t x;
      x = e;
      i_set_field = 3'd0;
      x.cyc = cyc + 4;
      q_tick.push_back(x);
      q_tick_nm.push_back(nm);
      repeat (4) step();
      i_set_field = 3'd1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
      $fatal(1);
   end

   initial begin
      do_reset();
      snap("reset_state", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

      // Full rollover, alarm at 00:00 but disabled.
      set_time(23, 59, 59, 31, 12, 99, 31);
      snap("setup_eoy", mk(23, 59, 59, 31, 12, 99, 23, 1, 0));
      release_tick("year_rollover", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));

      set_time(23, 59, 59, 28, 2, 1, 28);
      release_tick("feb28_nonleap", mk(0, 0, 0, 1, 3, 1, 0, 0, 0));

      set_time(23, 59, 59, 28, 2, 4, 29);
      release_tick("feb28_leap", mk(0, 0, 0, 29, 2, 4, 0, 0, 0));
      pulse(3, 1'b0, 1);
      pulse(2, 1'b0, 1);
      pulse(1, 1'b0, 1);
      release_tick("feb29_leap", mk(0, 0, 0, 1, 3, 4, 0, 0, 0));

      // Day clamp on month and year edits.
      set_time(0, 0, 0, 31, 1, 1, 31);
      pulse(5, 1'b1, 1);
      snap("clamp_month_inc", mk(0, 0, 0, 28, 2, 1, 0, 0, 0));
      pulse(6, 1'b0, 1);
      snap("clamp_year_dec", mk(0, 0, 0, 28, 2, 0, 0, 0, 0));

      // Seconds decrement wraps without borrow; set mode suppresses ticks.
      do_reset();
      pulse(1, 1'b0, 1);
      snap("sec_dec_wrap", mk(0, 0, 59, 1, 1, 0, 0, 0, 0));
      repeat (20) step();
      snap("set_hold_20", mk(0, 0, 59, 1, 1, 0, 0, 0, 0));
      release_tick("first_tick_after_set", mk(0, 1, 0, 1, 1, 0, 0, 0, 0));

      // Alarm.
      i_alarm_hour = 5'd7;
      i_alarm_min = 6'd30;
      i_alarm_en = 1'b1;
      set_time(7, 29, 59, 1, 1, 0, 31);
      release_tick("alarm_tick", mk(7, 30, 0, 1, 1, 0, 7, 0, 1));
      snap("alarm_one_cycle", mk(7, 30, 0, 1, 1, 0, 7, 0, 0));
      i_set_field = 3'd2;
      i_set_inc = 1'b1;
      i_set_dec = 1'b1;
      step();
      i_set_inc = 1'b0;
      i_set_dec = 1'b0;
      step();
      snap("inc_dec_together", mk(7, 30, 0, 1, 1, 0, 7, 0, 0));
      pulse(2, 1'b0, 1);
      pulse(2, 1'b1, 1);
      snap("set_no_alarm", mk(7, 30, 0, 1, 1, 0, 7, 0, 0));
      i_run = 1'b0;
      i_set_field = 3'd7;
      i_set_inc = 1'b1;
      step();
      i_set_inc = 1'b0;
      step();
      snap("field7_ignored", mk(7, 30, 0, 1, 1, 0, 7, 0, 0));
      i_set_field = 3'd1;
      i_run = 1'b1;
      i_alarm_en = 1'b0;

      // 12 h display.
      do_reset();
      i_mode_12h = 1'b1;
      snap("h12_midnight", mk(0, 0, 0, 1, 1, 0, 12, 0, 0));
      pulse(3, 1'b1, 12);
      snap("h12_noon", mk(12, 0, 0, 1, 1, 0, 12, 1, 0));
      pulse(3, 1'b1, 1);
      snap("h12_13", mk(13, 0, 0, 1, 1, 0, 1, 1, 0));
      pulse(3, 1'b0, 2);
      snap("h12_11", mk(11, 0, 0, 1, 1, 0, 11, 0, 0));
      i_mode_12h = 1'b0;

      // Reset mid-count.
      set_time(23, 59, 59, 31, 12, 99, 31);
      i_set_field = 3'd0;
      step();
      step();
      reset = 1'b0;
      snap("reset_midcount", mk(0, 0, 0, 1, 1, 0, 0, 0, 0));
      i_set_field = 3'd1;
      step();
      reset = 1'b1;
      repeat (6) step();

      while (q_tick.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL %s: tick never seen, required %s", q_tick_nm.pop_front(), fmt(q_tick.pop_front()));
      end
      while (q_snap.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL %s: snapshot not taken, required %s", q_snap_nm.pop_front(), fmt(q_snap.pop_front()));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
